// File: rtl/uart_cmd_ctrl_if.sv
// Bundles the UART byte stream, DDR2 request handshake and error strobe used by uart_cmd_ctrl.
// master = frame controller side, slave = host/DDR2 side.
interface uart_cmd_ctrl_if #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 2
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_wr;
  logic [8*ADDR_BYTES-1:0] cmd_addr;
  logic [8*DATA_BYTES-1:0] cmd_wdata;
  logic                    busy;
  logic                    err_pulse;
  logic [1:0]              err_code;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, busy, err_pulse, err_code
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, busy, err_pulse, err_code
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses UART host frames into single DDR2 read/write requests; cmd_valid rises the cycle after the checksum byte.
// Request is held stable until cmd_ready; bytes arriving while a request is pending are dropped as overrun.
module uart_cmd_ctrl #(
  parameter int         ADDR_BYTES  = 3,
  parameter int         DATA_BYTES  = 2,
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         TIMEOUT_CYC = 520700,
  parameter int         TO_W        = 20
) (
  input  logic            clk,
  input  logic            reset,
  uart_cmd_ctrl_if.master bus
);
  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0]   ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0]   DATA_LAST = CW'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_OPCODE  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_ISSUE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            wr_q;
  logic [AW-1:0]   addr_sh;
  logic [DW-1:0]   data_sh;
  logic [7:0]      csum;

  logic            in_frame;
  logic            timeout_hit;
  logic            err_set;
  logic [1:0]      err_nxt;
  logic            load_cmd;
  logic            cnt_clr;

  assign in_frame = (state == S_OPC) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CSUM);

  // A byte landing on the expiry cycle takes priority over the timeout.
  assign timeout_hit = in_frame && !bus.rx_valid && (to_cnt == TO_LAST);

  assign bus.cmd_valid = (state == S_ISSUE);
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_nxt   = ERR_OVERRUN;
    load_cmd  = 1'b0;
    cnt_clr   = 1'b0;

    if (timeout_hit) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
      err_nxt   = ERR_TIMEOUT;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rx_valid && (bus.rx_data == HEADER)) begin
            state_nxt = S_OPC;
          end
        end
        S_OPC: begin
          if (bus.rx_valid) begin
            cnt_clr = 1'b1;
            if ((bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ)) begin
              state_nxt = S_ADDR;
            end else begin
              state_nxt = S_IDLE;
              err_set   = 1'b1;
              err_nxt   = ERR_OPCODE;
            end
          end
        end
        S_ADDR: begin
          if (bus.rx_valid && (byte_cnt == ADDR_LAST)) begin
            cnt_clr   = 1'b1;
            state_nxt = wr_q ? S_DATA : S_CSUM;
          end
        end
        S_DATA: begin
          if (bus.rx_valid && (byte_cnt == DATA_LAST)) begin
            cnt_clr   = 1'b1;
            state_nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == csum) begin
              load_cmd  = 1'b1;
              state_nxt = S_ISSUE;
            end else begin
              state_nxt = S_IDLE;
              err_set   = 1'b1;
              err_nxt   = ERR_CSUM;
            end
          end
        end
        S_ISSUE: begin
          if (bus.rx_valid) begin
            err_set = 1'b1;
            err_nxt = ERR_OVERRUN;
          end
          if (bus.cmd_ready) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame assembly: opcode, address/data shift registers and running checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      wr_q     <= 1'b0;
      addr_sh  <= '0;
      data_sh  <= '0;
      csum     <= '0;
    end else begin
      if (cnt_clr) begin
        byte_cnt <= '0;
      end else if (bus.rx_valid && ((state == S_ADDR) || (state == S_DATA))) begin
        byte_cnt <= byte_cnt + CW'(1);
      end

      if (bus.rx_valid) begin
        case (state)
          S_OPC: begin
            wr_q <= (bus.rx_data == OP_WRITE);
            csum <= bus.rx_data;
          end
          S_ADDR: begin
            addr_sh <= (addr_sh << 8) | AW'(bus.rx_data);
            csum    <= csum ^ bus.rx_data;
          end
          S_DATA: begin
            data_sh <= (data_sh << 8) | DW'(bus.rx_data);
            csum    <= csum ^ bus.rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Inter-byte timer only runs while a frame is partially assembled.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!in_frame || bus.rx_valid || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cmd_wr    <= 1'b0;
      bus.cmd_addr  <= '0;
      bus.cmd_wdata <= '0;
      bus.err_pulse <= 1'b0;
      bus.err_code  <= '0;
    end else begin
      if (load_cmd) begin
        bus.cmd_wr    <= wr_q;
        bus.cmd_addr  <= addr_sh;
        bus.cmd_wdata <= wr_q ? data_sh : '0;
      end
      bus.err_pulse <= err_set;
      if (err_set) begin
        bus.err_code <= err_nxt;
      end
    end
  end

endmodule
